// File: rtl/borrow_flipflop_if.sv
// borrow_flipflop_if: groups the data/reset/output signals of one borrow register.
interface borrow_flipflop_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d;
    logic             r;
    logic [WIDTH-1:0] q;
    modport master (output d, output r, input q);
    modport slave (input d, input r, output q);
endinterface

// File: rtl/borrow_flipflop.sv
// borrow_flipflop: holds the serial-subtractor borrow for one clock, synchronous active-low clear.
module borrow_flipflop #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic [WIDTH-1:0] D,
    input  logic             CLK,
    input  logic             R,
    output logic [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge CLK)
        r_q <= R ? D : RESET_VAL;
    assign Q = r_q;
endmodule

// File: tb/tb_borrow_flipflop.sv
// tb_borrow_flipflop: directed and randomized checks of the borrow register against a reference model.
module tb_borrow_flipflop;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    borrow_flipflop_if #(.WIDTH(1)) b1 ();
    borrow_flipflop_if #(.WIDTH(4)) b4 ();

    borrow_flipflop u1 (.D(b1.d), .CLK(clk), .R(b1.r), .Q(b1.q));
    borrow_flipflop #(.WIDTH(4), .RESET_VAL(4'hA)) u4 (.D(b4.d), .CLK(clk), .R(b4.r), .Q(b4.q));

    int errors = 0;
    int checks = 0;
    logic       exp1;
    logic [3:0] exp4;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: value latched at a rising edge is the pre-edge D, or the clear value while R is low.
    task automatic tick(input string tag);
        logic       n1;
        logic [3:0] n4;
        n1 = b1.r ? b1.d : 1'b0;
        n4 = b4.r ? b4.d : 4'hA;
        @(posedge clk);
        exp1 = n1;
        exp4 = n4;
        #1;
        check({tag, "_q1"}, {3'b0, b1.q}, {3'b0, exp1});
        check({tag, "_q4"}, b4.q, exp4);
    endtask

    initial begin
        b1.r = 1'b0; b1.d = 1'b1;
        b4.r = 1'b0; b4.d = 4'h5;
        @(negedge clk);
        tick("por_reset");

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b1.d = i[0];
            b4.d = 4'(i * 3 + 1);
            tick("reset_hold");
            check("reset_hold_never1", {3'b0, b1.q}, 4'h0);
        end

        @(negedge clk);
        b1.r = 1'b1; b1.d = 1'b1;
        b4.r = 1'b1; b4.d = 4'h5;
        tick("load_one");
        check("w4_load5", b4.q, 4'h5);
        #2;
        b1.d = 1'b0;
        b4.d = 4'h3;
        @(negedge clk);
        #1;
        check("d_change_clk_high", {3'b0, b1.q}, 4'h1);
        check("d_change_clk_high_w4", b4.q, 4'h5);
        tick("after_drop");

        @(negedge clk);
        b1.d = 1'b1;
        b4.d = 4'hF;
        tick("reload");
        @(negedge clk);
        #3;
        b1.r = 1'b0;
        b4.r = 1'b0;
        #4;
        check("mid_reset_no_async", {3'b0, b1.q}, 4'h1);
        check("mid_reset_no_async_w4", b4.q, 4'hF);
        tick("mid_reset_edge");

        tick("release_pre");
        #2;
        b1.r = 1'b1; b1.d = 1'b1;
        b4.r = 1'b1; b4.d = 4'h6;
        #2;
        check("release_late_q1", {3'b0, b1.q}, 4'h0);
        check("release_late_q4", b4.q, 4'hA);
        tick("release_next");

        repeat (200) begin
            @(negedge clk);
            #1;
            check("rand_hold_q1", {3'b0, b1.q}, {3'b0, exp1});
            check("rand_hold_q4", b4.q, exp4);
            b1.d = 1'($urandom);
            b1.r = ($urandom_range(0, 7) != 0);
            b4.d = 4'($urandom);
            b4.r = ($urandom_range(0, 7) != 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
